mul_div_unit: RTL and testbench

- Iterative RV32M multiply/divide execution unit.
- Sits between the register file read ports and the register file write port.
- Consumes rs1/rs2 operand data and produces a result plus destination index and write enable for the rd write port.
- Holds the core stalled, via busy_o, while an operation iterates.

---
 rtl/mul_div_unit_pkg.sv | 23 ++
 rtl/mul_div_sign_fix.sv | 12 +
 rtl/mul_div_unit.sv | 215 +++++++++++++++++++++
 tb/tb_mul_div_unit.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/mul_div_unit_pkg.sv
// Shared encodings for the iterative RV32M multiply/divide unit.
package mul_div_unit_pkg;

    typedef enum logic [2:0] {
        MULDIV_MUL    = 3'd0,
        MULDIV_MULH   = 3'd1,
        MULDIV_MULHSU = 3'd2,
        MULDIV_MULHU  = 3'd3,
        MULDIV_DIV    = 3'd4,
        MULDIV_DIVU   = 3'd5,
        MULDIV_REM    = 3'd6,
        MULDIV_REMU   = 3'd7
    } muldiv_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } muldiv_state_e;

    localparam logic [6:0] MULDIV_FUNCT7 = 7'b0000001;

endpackage

// File: rtl/mul_div_sign_fix.sv
// Conditional two's complement negate; doubles as absolute value.
module mul_div_sign_fix #(
    parameter int W = 32
) (
    input  logic [W-1:0] value,
    input  logic         neg,
    output logic [W-1:0] result
);

    assign result = neg ? (~value + W'(1)) : value;

endmodule

// File: rtl/mul_div_unit.sv
// Iterative RV32M multiply/divide unit, one bit per cycle.
// MULDIV_EARLY_OUT_EN lets trivial ops skip the iteration phase.
module mul_div_unit
    import mul_div_unit_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            start_i,
    input  logic [2:0]      funct3_i,
    input  logic [XLEN-1:0] rs1_data_i,
    input  logic [XLEN-1:0] rs2_data_i,
    input  logic [4:0]      rd_addr_i,
    output logic            busy_o,
    output logic            done_o,
    output logic            RegWrite_o,
    output logic [4:0]      rd_addr_o,
    output logic [XLEN-1:0] rd_data_o
);

    muldiv_state_e   state;
    muldiv_op_e      op, op_in;
    logic [CNT_W-1:0] cnt;
    logic [4:0]      rd_q;
    logic            neg, div_zero, ovf, mul_zero;
    logic [XLEN-1:0] a_save, opb, rem;
    logic [2*XLEN-1:0] prod;

    logic            a_signed, b_signed, neg_in;
    logic            div_zero_in, ovf_in, mul_zero_in;
    logic [XLEN-1:0] abs_a, abs_b;

    assign op_in = muldiv_op_e'(funct3_i);

    always_comb begin
        a_signed = 1'b0;
        b_signed = 1'b0;
        neg_in   = 1'b0;
        unique case (op_in)
            MULDIV_MULH, MULDIV_DIV: begin
                a_signed = 1'b1;
                b_signed = 1'b1;
                neg_in   = rs1_data_i[XLEN-1] ^ rs2_data_i[XLEN-1];
            end
            MULDIV_REM: begin
                a_signed = 1'b1;
                b_signed = 1'b1;
                neg_in   = rs1_data_i[XLEN-1];
            end
            MULDIV_MULHSU: begin
                a_signed = 1'b1;
                neg_in   = rs1_data_i[XLEN-1];
            end
            default: ;
        endcase
    end

    assign div_zero_in = op_in[2] && (rs2_data_i == '0);
    assign ovf_in = (op_in == MULDIV_DIV || op_in == MULDIV_REM)
                  && (rs1_data_i == {1'b1, {(XLEN-1){1'b0}}})
                  && (rs2_data_i == '1);
    assign mul_zero_in = !op_in[2]
                       && (rs1_data_i == '0 || rs2_data_i == '0);

    mul_div_sign_fix #(.W(XLEN)) u_abs_a (
        .value (rs1_data_i),
        .neg   (a_signed & rs1_data_i[XLEN-1]),
        .result(abs_a)
    );

    mul_div_sign_fix #(.W(XLEN)) u_abs_b (
        .value (rs2_data_i),
        .neg   (b_signed & rs2_data_i[XLEN-1]),
        .result(abs_b)
    );

    // Multiply: multiplier sits in prod low half and shifts out LSB first.
    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] mul_next;
    assign mul_sum  = {1'b0, prod[2*XLEN-1:XLEN]} + {1'b0, opb};
    assign mul_next = prod[0] ? {mul_sum, prod[XLEN-1:1]}
                              : {1'b0, prod[2*XLEN-1:1]};

    // Divide: prod low half holds dividend bits, refilled with quotient bits.
    logic [XLEN:0] div_shift, div_trial;
    assign div_shift = {rem, prod[XLEN-1]};
    assign div_trial = div_shift - {1'b0, opb};

    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quot_fix, rem_fix, result;

    mul_div_sign_fix #(.W(2*XLEN)) u_fix_prod (
        .value (prod),
        .neg   (neg),
        .result(prod_fix)
    );

    mul_div_sign_fix #(.W(XLEN)) u_fix_quot (
        .value (prod[XLEN-1:0]),
        .neg   (neg),
        .result(quot_fix)
    );

    mul_div_sign_fix #(.W(XLEN)) u_fix_rem (
        .value (rem),
        .neg   (neg),
        .result(rem_fix)
    );

    always_comb begin
        result = '0;
        unique case (op)
            MULDIV_MUL:
                result = prod_fix[XLEN-1:0];
            MULDIV_MULH, MULDIV_MULHSU, MULDIV_MULHU:
                result = prod_fix[2*XLEN-1:XLEN];
            MULDIV_DIV, MULDIV_DIVU:
                result = div_zero ? '1
                       : ovf ? {1'b1, {(XLEN-1){1'b0}}} : quot_fix;
            MULDIV_REM, MULDIV_REMU:
                result = div_zero ? a_save : ovf ? '0 : rem_fix;
        endcase
        if (mul_zero) result = '0;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state      <= IDLE;
            op         <= MULDIV_MUL;
            cnt        <= '0;
            rd_q       <= '0;
            neg        <= 1'b0;
            div_zero   <= 1'b0;
            ovf        <= 1'b0;
            mul_zero   <= 1'b0;
            a_save     <= '0;
            opb        <= '0;
            rem        <= '0;
            prod       <= '0;
            busy_o     <= 1'b0;
            done_o     <= 1'b0;
            RegWrite_o <= 1'b0;
            rd_addr_o  <= '0;
            rd_data_o  <= '0;
        end else begin
            done_o     <= 1'b0;
            RegWrite_o <= 1'b0;
            unique case (state)
                IDLE: begin
                    // busy_o still high here marks the done cycle; no accept.
                    if (start_i && !busy_o) begin
                        op       <= op_in;
                        rd_q     <= rd_addr_i;
                        neg      <= neg_in;
                        div_zero <= div_zero_in;
                        ovf      <= ovf_in;
                        mul_zero <= mul_zero_in;
                        a_save   <= rs1_data_i;
                        rem      <= '0;
                        busy_o   <= 1'b1;
                        if (op_in[2]) begin
                            prod <= {{XLEN{1'b0}}, abs_a};
                            opb  <= abs_b;
                        end else begin
                            prod <= {{XLEN{1'b0}}, abs_b};
                            opb  <= abs_a;
                        end
`ifdef MULDIV_EARLY_OUT_EN
                        if (div_zero_in || ovf_in || mul_zero_in) begin
                            cnt   <= CNT_W'(1);
                            state <= DONE;
                        end else begin
                            cnt   <= CNT_W'(XLEN);
                            state <= CALC;
                        end
`else
                        cnt   <= CNT_W'(XLEN);
                        state <= CALC;
`endif
                    end else begin
                        busy_o <= 1'b0;
                    end
                end
                CALC: begin
                    cnt <= cnt - CNT_W'(1);
                    if (op[2]) begin
                        rem  <= div_trial[XLEN] ? div_shift[XLEN-1:0]
                                                : div_trial[XLEN-1:0];
                        prod <= {prod[2*XLEN-1:XLEN],
                                 prod[XLEN-2:0], ~div_trial[XLEN]};
                    end else begin
                        prod <= mul_next;
                    end
                    if (cnt == CNT_W'(1)) state <= DONE;
                end
                DONE: begin
                    // A non-zero count here is the early-out settle cycle.
                    if (cnt != '0) begin
                        cnt <= cnt - CNT_W'(1);
                    end else begin
                        rd_data_o  <= result;
                        rd_addr_o  <= rd_q;
                        done_o     <= 1'b1;
                        RegWrite_o <= (rd_q != 5'd0);
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed vector bench for mul_div_unit.
module tb_mul_div_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [2:0]  funct3;
    logic [31:0] rs1, rs2;
    logic [4:0]  rd;
    logic        busy, done, regwrite;
    logic [4:0]  rd_addr;
    logic [31:0] rd_data;

    int applied = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    mul_div_unit dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .start_i   (start),
        .funct3_i  (funct3),
        .rs1_data_i(rs1),
        .rs2_data_i(rs2),
        .rd_addr_i (rd),
        .busy_o    (busy),
        .done_o    (done),
        .RegWrite_o(regwrite),
        .rd_addr_o (rd_addr),
        .rd_data_o (rd_data)
    );

    typedef struct {
        string       name;
        logic [2:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic [31:0] exp;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        applied++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
        end
    endtask

    function automatic int exp_lat(input logic [2:0] f,
                                   input logic [31:0] a,
                                   input logic [31:0] b);
        bit special;
        special = (f[2] && b == 0)
               || ((f == 3'd4 || f == 3'd6) && a == 32'h8000_0000
                   && b == 32'hFFFF_FFFF)
               || (!f[2] && (a == 0 || b == 0));
`ifdef MULDIV_EARLY_OUT_EN
        return special ? 2 : 33;
`else
        return special ? 33 : 33;
`endif
    endfunction

    task automatic run_op(input logic [2:0] f, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] r,
                          output logic [31:0] data, output int lat,
                          output logic rw, output logic [4:0] addr,
                          output logic busy_ok, output logic hold_ok);
        @(negedge clk);
        start = 1'b1; funct3 = f; rs1 = a; rs2 = b; rd = r;
        @(negedge clk);
        start = 1'b0;
        lat = 0;
        busy_ok = busy;
        while (!done && lat < 100) begin
            @(negedge clk);
            lat++;
            busy_ok = busy_ok & busy;
        end
        data = rd_data;
        rw   = regwrite;
        addr = rd_addr;
        @(negedge clk);
        hold_ok = !done && !busy && (rd_data === data);
    endtask

    vec_t vecs[$];

    initial begin
        logic [31:0] data;
        logic [4:0]  addr;
        logic        rw, bok, hok;
        int          lat, pulses;

        vecs.push_back('{"mul_7_m3",     3'd0, 32'd7,        32'hFFFF_FFFD, 5'd5,  32'hFFFF_FFEB});
        vecs.push_back('{"mulhu_ff",     3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1,  32'hFFFF_FFFE});
        vecs.push_back('{"mulh_ff",      3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2,  32'h0000_0000});
        vecs.push_back('{"mulhsu_ff",    3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3,  32'hFFFF_FFFF});
        vecs.push_back('{"mul_lo",       3'd0, 32'h1234_5678, 32'h0000_0010, 5'd4,  32'h2345_6780});
        vecs.push_back('{"mulhu_2",      3'd3, 32'h8000_0000, 32'd4,        5'd6,  32'd2});
        vecs.push_back('{"mul_zero",     3'd0, 32'h0000_0000, 32'h1234_5678, 5'd7,  32'd0});
        vecs.push_back('{"div_m20_3",    3'd4, 32'hFFFF_FFEC, 32'd3,        5'd8,  32'hFFFF_FFFA});
        vecs.push_back('{"rem_m20_3",    3'd6, 32'hFFFF_FFEC, 32'd3,        5'd9,  32'hFFFF_FFFE});
        vecs.push_back('{"divu_20_3",    3'd5, 32'd20,       32'd3,        5'd10, 32'd6});
        vecs.push_back('{"remu_20_3",    3'd7, 32'd20,       32'd3,        5'd11, 32'd2});
        vecs.push_back('{"div_7_m2",     3'd4, 32'd7,        32'hFFFF_FFFE, 5'd12, 32'hFFFF_FFFD});
        vecs.push_back('{"rem_7_m2",     3'd6, 32'd7,        32'hFFFF_FFFE, 5'd13, 32'd1});
        vecs.push_back('{"div_by0",      3'd4, 32'h1234,     32'd0,        5'd14, 32'hFFFF_FFFF});
        vecs.push_back('{"rem_by0",      3'd6, 32'h1234,     32'd0,        5'd15, 32'h1234});
        vecs.push_back('{"divu_by0",     3'd5, 32'h1234,     32'd0,        5'd16, 32'hFFFF_FFFF});
        vecs.push_back('{"remu_by0",     3'd7, 32'h1234,     32'd0,        5'd17, 32'h1234});
        vecs.push_back('{"div_ovf",      3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd18, 32'h8000_0000});
        vecs.push_back('{"rem_ovf",      3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd19, 32'd0});
        vecs.push_back('{"mul_rd0",      3'd0, 32'd2,        32'd2,        5'd0,  32'd4});

        rst = 1'b1; start = 1'b0; funct3 = '0; rs1 = '0; rs2 = '0; rd = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy",   {31'd0, busy},     32'd0);
        chk("rst_done",   {31'd0, done},     32'd0);
        chk("rst_regw",   {31'd0, regwrite}, 32'd0);
        chk("rst_rdaddr", {27'd0, rd_addr},  32'd0);
        chk("rst_rddata", rd_data,           32'd0);
        rst = 1'b0;

        foreach (vecs[i]) begin
            run_op(vecs[i].f, vecs[i].a, vecs[i].b, vecs[i].rd,
                   data, lat, rw, addr, bok, hok);
            chk({vecs[i].name, "_data"}, data, vecs[i].exp);
            chk({vecs[i].name, "_lat"}, lat,
                exp_lat(vecs[i].f, vecs[i].a, vecs[i].b));
            chk({vecs[i].name, "_regw"}, {31'd0, rw},
                {31'd0, vecs[i].rd != 5'd0});
            chk({vecs[i].name, "_rdaddr"}, {27'd0, addr},
                {27'd0, vecs[i].rd});
            chk({vecs[i].name, "_busy"}, {31'd0, bok}, 32'd1);
            chk({vecs[i].name, "_hold"}, {31'd0, hok}, 32'd1);
        end

        // start held high while busy: one op, one done pulse
        @(negedge clk);
        start = 1'b1; funct3 = 3'd0; rs1 = 32'd3; rs2 = 32'd5; rd = 5'd7;
        @(negedge clk);
        funct3 = 3'd5; rs1 = 32'd99; rs2 = 32'd0;
        repeat (10) @(negedge clk);
        start = 1'b0;
        pulses = 0;
        data = '0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (done) begin
                pulses++;
                data = rd_data;
            end
        end
        chk("restart_pulses", pulses, 1);
        chk("restart_data", data, 32'd15);
        chk("restart_idle", {31'd0, busy}, 32'd0);

        // reset in the middle of a divide aborts it
        @(negedge clk);
        start = 1'b1; funct3 = 3'd4; rs1 = 32'd1000; rs2 = 32'd7; rd = 5'd9;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_done", {31'd0, done}, 32'd0);
        rst = 1'b0;
        pulses = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (done) pulses++;
        end
        chk("abort_nodone", pulses, 0);
        run_op(3'd5, 32'd100, 32'd7, 5'd21, data, lat, rw, addr, bok, hok);
        chk("after_abort_data", data, 32'd14);
        chk("after_abort_lat", lat, 33);
        chk("after_abort_regw", {31'd0, rw}, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==",
                 applied, miscompares);
        $finish;
    end

endmodule
